// File: rtl/stack_mem_ctrl.sv
// stack_mem_ctrl: sequences push/pop/peek/clear commands onto a single-port
// synchronous stack RAM, owns the stack pointer and reports done/err.
module stack_mem_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] wdata,
  output logic              op_ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W:0]   sp,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] SP_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] SP_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_CAPTURE, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_PEEK  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  state_t          state;
  op_t             op_q;
  logic [ADDR_W:0] sp_dec;

  assign sp_dec   = sp - SP_ONE;
  assign op_ready = (state == S_IDLE);
  assign full     = (sp == SP_MAX);
  assign empty    = (sp == '0);

  // Command sequencer; outputs are registered on the transition into the
  // state that owns them so mem_we/mem_addr/done line up with that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_PUSH;
      sp        <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            op_q <= op_t'(op);
            case (op_t'(op))
              OP_PUSH: begin
                if (full) begin
                  state <= S_ERR;
                  done  <= 1'b1;
                  err   <= 1'b1;
                end else begin
                  state     <= S_WRITE;
                  mem_we    <= 1'b1;
                  mem_addr  <= sp[ADDR_W-1:0];
                  mem_wdata <= wdata;
                end
              end
              OP_POP, OP_PEEK: begin
                if (empty) begin
                  state <= S_ERR;
                  done  <= 1'b1;
                  err   <= 1'b1;
                end else begin
                  state    <= S_READ;
                  mem_addr <= sp_dec[ADDR_W-1:0];
                end
              end
              default: begin
                sp    <= '0;
                state <= S_DONE;
                done  <= 1'b1;
              end
            endcase
          end
        end
        S_WRITE: begin
          sp       <= sp + SP_ONE;
          state    <= S_DONE;
          done     <= 1'b1;
          mem_addr <= '0;
        end
        S_READ: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rdata <= mem_rdata;
          if (op_q == OP_POP) sp <= sp_dec;
          state    <= S_DONE;
          done     <= 1'b1;
          mem_addr <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Self-checking bench for stack_mem_ctrl with a behavioural RAM and a
// queue-based stack reference model.
module tb_stack_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic [1:0] op;
  logic [7:0] wdata;
  logic       op_ready, done, err, full, empty, mem_we;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [5:0] sp;
  logic [4:0] mem_addr;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram [32];
  logic [7:0] stk [$];
  logic [7:0] mrd;
  int         wlog_addr [$];
  logic [7:0] wlog_data [$];

  stack_mem_ctrl #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .wdata(wdata),
    .op_ready(op_ready), .done(done), .err(err), .rdata(rdata), .sp(sp),
    .full(full), .empty(empty), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Record every RAM write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wlog_addr.push_back(int'(mem_addr));
      wlog_data.push_back(mem_wdata);
    end
  end

  // Reference stack: expected latency, error flag and written address (-1 none).
  task automatic model_apply(input logic [1:0] o, input logic [7:0] d,
                             output int xl, output logic xe, output int xaddr);
    xe = 1'b0; xaddr = -1; xl = 0;
    case (o)
      2'd0: if (stk.size() == 32) begin xl = 1; xe = 1'b1; end
            else begin xaddr = stk.size(); stk.push_back(d); xl = 2; end
      2'd1: if (stk.size() == 0) begin xl = 1; xe = 1'b1; end
            else begin mrd = stk.pop_back(); xl = 3; end
      2'd2: if (stk.size() == 0) begin xl = 1; xe = 1'b1; end
            else begin mrd = stk[stk.size()-1]; xl = 3; end
      default: begin stk.delete(); xl = 1; end
    endcase
  endtask

  // Issue one command and wait (bounded) for done; lat=0 means no done seen.
  task automatic do_op(input logic [1:0] o, input logic [7:0] d, output int lat,
                       output logic e, output logic [7:0] rd, output logic [5:0] s,
                       output logic f, output logic em);
    int guard;
    guard = 0;
    lat = 0; e = 1'bx; rd = 8'hxx; s = 6'hxx; f = 1'bx; em = 1'bx;
    @(negedge clk);
    while (!op_ready && guard < 20) begin @(negedge clk); guard++; end
    op_valid = 1'b1; op = o; wdata = d;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 2'($urandom); wdata = 8'($urandom);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n; e = err; rd = rdata; s = sp; f = full; em = empty;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stk.delete(); mrd = 8'h00;
  endtask

  // Run one command through both DUT and model and compare everything.
  task automatic check_op(input string nm, input logic [1:0] o, input logic [7:0] d);
    int lat, xl, xaddr, wn;
    logic e, xe, f, em;
    logic [7:0] rd;
    logic [5:0] s;
    wn = wlog_addr.size();
    model_apply(o, d, xl, xe, xaddr);
    do_op(o, d, lat, e, rd, s, f, em);
    total++; if (lat !== xl) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, xl); end
    total++; if (e !== xe) begin bad++; $display("FAIL %s_err got=%b exp=%b", nm, e, xe); end
    total++; if (rd !== mrd) begin bad++; $display("FAIL %s_rdata got=%h exp=%h", nm, rd, mrd); end
    total++; if (s !== 6'(stk.size())) begin bad++; $display("FAIL %s_sp got=%0d exp=%0d", nm, s, stk.size()); end
    total++; if (f !== (stk.size() == 32) || em !== (stk.size() == 0)) begin
      bad++; $display("FAIL %s_flags got full=%b empty=%b exp size=%0d", nm, f, em, stk.size()); end
    if (xaddr >= 0) begin
      total++;
      if (wlog_addr.size() != wn + 1 || wlog_addr[wn] != xaddr || wlog_data[wn] !== d) begin
        bad++; $display("FAIL %s_write got n=%0d exp addr=%0d data=%h", nm, wlog_addr.size() - wn, xaddr, d);
      end
    end else begin
      total++;
      if (wlog_addr.size() != wn) begin
        bad++; $display("FAIL %s_nowrite got %0d writes exp 0", nm, wlog_addr.size() - wn);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (sp !== 6'd0) begin bad++; $display("FAIL reset_sp got=%0d exp=0", sp); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
    total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", op_ready); end
    total++; if (done !== 1'b0 || err !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got done=%b err=%b we=%b exp 0", done, err, mem_we); end
    total++; if (rdata !== 8'h00 || mem_addr !== 5'd0 || mem_wdata !== 8'h00) begin
      bad++; $display("FAIL reset_data got rdata=%h addr=%0d wdata=%h exp 0", rdata, mem_addr, mem_wdata); end
  endtask

  task automatic test_lifo();
    apply_reset();
    check_op("lifo_push", 2'd0, 8'h11);
    check_op("lifo_push", 2'd0, 8'h22);
    check_op("lifo_push", 2'd0, 8'h33);
    check_op("lifo_pop", 2'd1, 8'h00);
    total++; if (rdata !== 8'h33) begin bad++; $display("FAIL lifo_pop1 got=%h exp=33", rdata); end
    check_op("lifo_pop", 2'd1, 8'h00);
    total++; if (rdata !== 8'h22) begin bad++; $display("FAIL lifo_pop2 got=%h exp=22", rdata); end
    check_op("lifo_pop", 2'd1, 8'h00);
    total++; if (rdata !== 8'h11 || sp !== 6'd0) begin bad++; $display("FAIL lifo_pop3 got=%h sp=%0d exp=11 sp=0", rdata, sp); end
  endtask

  task automatic test_overflow();
    logic [7:0] w31;
    apply_reset();
    for (int i = 0; i < 32; i++) check_op("ovf_fill", 2'd0, 8'($urandom));
    w31 = stk[31];
    check_op("ovf_push", 2'd0, 8'hAA);
    total++; if (sp !== 6'd32 || full !== 1'b1) begin bad++; $display("FAIL ovf_state got sp=%0d full=%b exp 32/1", sp, full); end
    check_op("ovf_pop", 2'd1, 8'h00);
    total++; if (rdata !== w31) begin bad++; $display("FAIL ovf_word31 got=%h exp=%h", rdata, w31); end
  endtask

  task automatic test_underflow();
    apply_reset();
    check_op("udf_pop", 2'd1, 8'h00);
    check_op("udf_peek", 2'd2, 8'h00);
    total++; if (rdata !== 8'h00 || sp !== 6'd0) begin bad++; $display("FAIL udf_state got rdata=%h sp=%0d exp 0/0", rdata, sp); end
  endtask

  task automatic test_peek_clear();
    apply_reset();
    check_op("pc_push", 2'd0, 8'h5A);
    check_op("pc_peek", 2'd2, 8'h00);
    total++; if (rdata !== 8'h5A || sp !== 6'd1) begin bad++; $display("FAIL pc_peek got rdata=%h sp=%0d exp 5a/1", rdata, sp); end
    check_op("pc_clear", 2'd3, 8'h00);
    total++; if (sp !== 6'd0 || empty !== 1'b1) begin bad++; $display("FAIL pc_clear got sp=%0d empty=%b exp 0/1", sp, empty); end
  endtask

  task automatic test_reset_midop();
    int dn, wr;
    apply_reset();
    check_op("rm_pre", 2'd0, 8'h77);
    @(negedge clk);
    op_valid = 1'b1; op = 2'd0; wdata = 8'h99;
    @(posedge clk); #1;
    op_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    stk.delete(); mrd = 8'h00;
    dn = 0; wr = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || err) dn++;
      if (mem_we) wr++;
    end
    total++; if (dn != 0) begin bad++; $display("FAIL rm_done got=%0d exp=0", dn); end
    total++; if (wr != 0) begin bad++; $display("FAIL rm_write got=%0d exp=0", wr); end
    total++; if (sp !== 6'd0 || rdata !== 8'h00 || op_ready !== 1'b1) begin
      bad++; $display("FAIL rm_state got sp=%0d rdata=%h ready=%b exp 0/00/1", sp, rdata, op_ready); end
  endtask

  task automatic test_held_valid();
    int acc, wn;
    apply_reset();
    wn = wlog_addr.size();
    acc = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      op_valid = 1'b1; op = 2'd0; wdata = 8'h40 + 8'(i);
      if (op_ready) acc++;
      @(negedge clk);
    end
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    stk.push_back(8'h40); stk.push_back(8'h43);
    total++; if (acc != 2) begin bad++; $display("FAIL held_accepts got=%0d exp=2", acc); end
    total++; if (sp !== 6'd2) begin bad++; $display("FAIL held_sp got=%0d exp=2", sp); end
    total++;
    if (wlog_addr.size() != wn + 2 || wlog_addr[wn] != 0 || wlog_data[wn] !== 8'h40 ||
        wlog_addr[wn+1] != 1 || wlog_data[wn+1] !== 8'h43) begin
      bad++; $display("FAIL held_writes got n=%0d exp 2 writes 0:40 1:43", wlog_addr.size() - wn);
    end
    check_op("held_pop", 2'd1, 8'h00);
  endtask

  task automatic test_random();
    int r;
    logic [1:0] o;
    apply_reset();
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      o = (r < 55) ? 2'd0 : (r < 75) ? 2'd1 : (r < 96) ? 2'd2 : 2'd3;
      check_op("rand", o, 8'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 8'h00;
    rst = 1'b1; op_valid = 1'b0; op = 2'd0; wdata = 8'h00; mrd = 8'h00;
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_peek_clear();
    test_reset_midop();
    test_held_valid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_mem_ctrl.md
# stack_mem_ctrl

Sequencer for the processor's stack memory. Accepts one push/pop/peek/clear command at a time from the main instruction controller over a valid/ready handshake, owns the stack pointer, and drives a single-port synchronous stack RAM. Replaces the ad-hoc push/pop strobes with a checked, multicycle protocol that reports completion, overflow and underflow.

## Interface
Parameters:
- DATA_W, 8, stack word width
- ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W words (derived, not overridable)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- op_valid  in  1  command present
- op  in  2  00 PUSH, 01 POP, 10 PEEK, 11 CLEAR
- wdata  in  DATA_W  push operand
- op_ready  out  1  controller idle, command accepted this cycle if op_valid
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, on overflow/underflow
- rdata  out  DATA_W  result of last successful POP/PEEK (registered)
- sp  out  ADDR_W+1  word count = next free address
- full  out  1  sp == DEPTH
- empty  out  1  sp == 0
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write strobe
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after address is presented

## Operation
- States: IDLE, WRITE, READ, CAPTURE, DONE, ERR.
- IDLE: op_ready=1. On op_valid, latch op and wdata, then branch:
  - PUSH & full -> ERR; PUSH -> WRITE
  - POP/PEEK & empty -> ERR; POP/PEEK -> READ
  - CLEAR -> sp<=0, -> DONE
- WRITE: mem_we=1, mem_addr=sp[ADDR_W-1:0], mem_wdata=latched wdata; sp<=sp+1; -> DONE.
- READ: mem_addr=sp-1; -> CAPTURE.
- CAPTURE: mem_addr held at sp-1; rdata<=mem_rdata; POP only: sp<=sp-1; -> DONE.
- DONE: done=1; -> IDLE.
- ERR: done=1, err=1; sp, rdata, RAM untouched; -> IDLE.
- op_valid outside IDLE is ignored; op/wdata changes after acceptance have no effect.
- mem_we is high only in WRITE. mem_addr is 0 in IDLE/DONE/ERR.
- sp never wraps: pushes at sp==DEPTH and pops/peeks at sp==0 are rejected via ERR.
- full/empty are combinational from sp.
- Reset values: state IDLE, sp=0, rdata=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0; op_ready=1, empty=1, full=0.
- Reset mid-operation: in-flight command discarded, no done/err, no write issued after the reset edge, sp=0 (stack logically cleared; RAM contents are don't-care).

## Timing
- Cycle 0 = cycle with op_valid & op_ready high.
- PUSH: WRITE in cycle 1, done in cycle 2, new sp visible in cycle 2. Next accept at the earliest in cycle 3.
- POP/PEEK: READ cycle 1, CAPTURE cycle 2, done in cycle 3 with rdata valid; POP's decremented sp visible in cycle 3.
- CLEAR: done in cycle 1, sp=0 in cycle 1.
- Overflow/underflow: done=err=1 in cycle 1.
- Throughput: one command per 2 (CLEAR/ERR), 3 (PUSH) or 4 (POP/PEEK) cycles, including the IDLE accept cycle.
- rdata stable from done until the next successful POP/PEEK completes.

## Test plan
- Reset: hold rst 2 cycles -> sp=0, empty=1, full=0, op_ready=1, done=err=mem_we=0, rdata=0.
- LIFO: PUSH 0x11, 0x22, 0x33, then 3×POP -> rdata 0x33, 0x22, 0x11 at done; sp 3->0; mem_we pulses at addr 0,1,2 only; each PUSH done 2 cycles and each POP done 3 cycles after accept.
- Overflow: fill DEPTH=32 words, PUSH 0xAA -> done=err=1 in cycle 1, no mem_we, sp=32, full=1; POP -> rdata = word 31.
- Underflow: after reset, POP and PEEK -> each err=1 with done, sp=0, rdata unchanged (0).
- PEEK/CLEAR: PUSH 0x5A, PEEK -> rdata 0x5A, sp stays 1; CLEAR -> done in cycle 1, sp=0, empty=1.
- Reset mid-op and held valid: assert rst during a PUSH in WRITE -> no done, sp=0; op_valid held high across 2 PUSHes -> exactly one accept per IDLE visit and sp=2.
